// File: rtl/adc_serial_reader_if.sv
// Sample-side bundle of the RED channel ADC reader.
// The master is the reader: it drives the ADC control pins and produces
// the captured sample. The slave is the ADC, the requester and the consumer.
interface adc_serial_reader_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              clear_ovr;
  logic              SDATA;
  logic              CS_n;
  logic              SCLK;
  logic [DATA_W-1:0] RED_ADC_Value;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  modport master (
    input  start, clear_ovr, SDATA,
    output CS_n, SCLK, RED_ADC_Value, sample_valid, busy, overrun
  );

  modport slave (
    output start, clear_ovr, SDATA,
    input  CS_n, SCLK, RED_ADC_Value, sample_valid, busy, overrun
  );
endinterface

// File: rtl/adc_serial_reader.sv
// Serial 8-bit ADC front end for the RED sensor channel.
// Runs one CS_n/SCLK frame per accepted start request, keeps the data-window
// bits MSB first and publishes them on RED_ADC_Value with a one-cycle
// sample_valid strobe. Every output comes straight from a register.
module adc_serial_reader #(
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 3,
  parameter int DIV        = 2,
  parameter int QUIET_CYC  = 4
) (
  input  logic                CLK_Filter,
  input  logic                rst,
  adc_serial_reader_if.master bus
);

  // SETUP holds SCLK high one cycle longer than a normal half period so the
  // first SCLK fall lands 1+DIV cycles after CS_n falls.
  localparam int DC_W = $clog2(DIV + 1);
  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam int QC_W = $clog2(QUIET_CYC + 1);

  localparam logic [DC_W-1:0] HALF_LAST  = DC_W'(DIV - 1);
  localparam logic [DC_W-1:0] SETUP_LAST = DC_W'(DIV);
  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0] WIN_LO     = BC_W'(LEAD_BITS);
  localparam logic [BC_W-1:0] WIN_HI     = BC_W'(LEAD_BITS + DATA_W);
  localparam logic [QC_W-1:0] QUIET_LAST = QC_W'(QUIET_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    QUIET
  } state_t;

  state_t            state;
  logic [DC_W-1:0]   div_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [QC_W-1:0]   quiet_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] red_value;
  logic              cs_n;
  logic              sclk;
  logic              valid;
  logic              busy;
  logic              ovr;
  logic              in_window;

  assign in_window = (bit_cnt >= WIN_LO) && (bit_cnt < WIN_HI);

  assign bus.CS_n          = cs_n;
  assign bus.SCLK          = sclk;
  assign bus.RED_ADC_Value = red_value;
  assign bus.sample_valid  = valid;
  assign bus.busy          = busy;
  assign bus.overrun       = ovr;

  // Frame sequencer: chip select, serial clock, bit capture and sample hand-off.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      shift_reg <= '0;
      red_value <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == SETUP_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= SHIFT_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= SHIFT_HI;
            if (in_window) begin
              shift_reg <= {shift_reg[DATA_W-2:0], bus.SDATA};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (bit_cnt < LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b0;
              state   <= SHIFT_LO;
            end else begin
              cs_n      <= 1'b1;
              red_value <= shift_reg;
              valid     <= 1'b1;
              quiet_cnt <= '0;
              state     <= QUIET;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        QUIET: begin
          if (quiet_cnt == QUIET_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a request while busy sets it, and setting beats clearing.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (bus.start && busy) begin
      ovr <= 1'b1;
    end else if (bus.clear_ovr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed-plus-random bench for adc_serial_reader with a behavioural ADC
// that shifts out queued 16-bit frames on falling SCLK edges.
module tb_adc_serial_reader;

  localparam int DIV       = 2;
  localparam int FIRST_LO  = 1 + DIV;               // first SCLK fall after E
  localparam int T_VALID   = 1 + DIV * (1 + 2 * 16); // 67
  localparam int T_IDLE    = T_VALID + 4;            // 71
  localparam int SPACING   = T_IDLE + 1;             // 72

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_serial_reader_if #(.DATA_W(8)) bus ();

  adc_serial_reader #(
    .DATA_W(8), .FRAME_BITS(16), .LEAD_BITS(3), .DIV(DIV), .QUIET_CYC(4)
  ) dut (
    .CLK_Filter(clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_val = 8'h00;

  // Behavioural ADC: each frame is {lead[2:0], data[7:0], trail[4:0]}, sent
  // MSB first, one bit presented per falling SCLK edge while selected.
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = 16'h0;
  int          fall_n = 0;

  always @(negedge bus.CS_n) begin
    cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0;
    fall_n = 0;
  end

  always @(negedge bus.SCLK) begin
    if (!bus.CS_n && fall_n < 16) begin
      bus.SDATA = cur_frame[15 - fall_n];
      fall_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sclk_model(input int n);
    if (n >= FIRST_LO && n < T_VALID)
      return ((n - FIRST_LO) / DIV) % 2 == 1;
    return 1'b1;
  endfunction

  // One frame from a start pulse, checked cycle by cycle out to E+105.
  // restart_at/clear_at (0 = unused) pulse start/clear_ovr at that edge.
  task automatic do_frame(input logic [7:0] d, input logic [2:0] l, input logic [4:0] t,
                          input int restart_at, input int clear_at);
    logic exp_ovr;
    frame_q.push_back({l, d, t});
    bus.clear_ovr = 1'b1;
    tick();
    bus.clear_ovr = 1'b0;
    chk("ovr_pre", bus.overrun, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("cs_fall", bus.CS_n, 0);
    chk("busy_rise", bus.busy, 1);
    for (int n = 1; n <= 105; n++) begin
      bus.start     = (n == restart_at);
      bus.clear_ovr = (n == clear_at);
      tick();
      if (n == T_VALID) exp_val = d;
      chk("valid", bus.sample_valid, (n == T_VALID));
      chk("busy", bus.busy, (n < T_IDLE));
      chk("cs_n", bus.CS_n, (n >= T_VALID));
      chk("sclk", bus.SCLK, sclk_model(n));
      chk("value", bus.RED_ADC_Value, exp_val);
      if (restart_at > 0) begin
        exp_ovr = (n >= restart_at) && !(clear_at > restart_at && n >= clear_at);
        chk("overrun", bus.overrun, exp_ovr);
      end
    end
    bus.start = 1'b0;
    bus.clear_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] held_vals[3];
    int         vidx;
    logic [7:0] rd;

    bus.start = 1'b0;
    bus.clear_ovr = 1'b0;

    // Reset, then no start: outputs stay quiet.
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", bus.busy, 0);
      chk("idle_cs", bus.CS_n, 1);
      chk("idle_sclk", bus.SCLK, 1);
    end
    chk("idle_value", bus.RED_ADC_Value, 8'h00);
    chk("idle_valid", bus.sample_valid, 0);
    chk("idle_ovr", bus.overrun, 0);

    // Clean frame, then garbage ones around the data window.
    do_frame(8'hA5, 3'b000, 5'b00000, 0, 0);
    do_frame(8'h3C, 3'b111, 5'b11111, 0, 0);

    // Overrun: re-request mid-frame then clear; then set and clear together.
    do_frame(8'hA5, 3'b000, 5'b00000, 20, 100);
    do_frame(8'h5A, 3'b010, 5'b10101, 30, 30);

    // Random data and random garbage bits.
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      do_frame(rd, 3'($urandom), 5'($urandom), 0, 0);
    end

    // Reset in the middle of a frame.
    frame_q.push_back({3'b000, 8'hC3, 5'b00000});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (29) tick();
    #2 rst = 1'b1;
    #1;
    exp_val = 8'h00;
    chk("rst_cs", bus.CS_n, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_value", bus.RED_ADC_Value, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.sample_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("rst_novalid", bus.sample_valid, 0);
      chk("rst_hold", bus.RED_ADC_Value, 8'h00);
    end
    rd = 8'($urandom);
    do_frame(rd, 3'($urandom), 5'($urandom), 0, 0);

    // start held high: one frame per IDLE visit, 72 cycles apart.
    held_vals[0] = 8'h01;
    held_vals[1] = 8'hFF;
    held_vals[2] = 8'h80;
    for (int i = 0; i < 3; i++)
      frame_q.push_back({3'($urandom), held_vals[i], 5'($urandom)});
    bus.clear_ovr = 1'b1;
    tick();
    bus.clear_ovr = 1'b0;
    bus.start = 1'b1;
    tick();
    vidx = 0;
    for (int n = 1; n <= 230; n++) begin
      tick();
      if (n % SPACING == T_VALID) begin
        exp_val = held_vals[vidx];
        vidx++;
      end
      chk("hold_valid", bus.sample_valid, (n % SPACING == T_VALID));
      chk("hold_busy", bus.busy, (n % SPACING != T_IDLE));
      chk("hold_value", bus.RED_ADC_Value, exp_val);
      chk("hold_ovr", bus.overrun, 1);
    end
    chk("hold_count", vidx, 3);
    bus.start = 1'b0;
    repeat (80) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
